signal_selector_n: RTL and testbench
====================================

# signal_selector_n

Parametrised N-channel successor to the 2:1 phase-signal selector: routes one of `N_CH` single-bit phase signals (`i_phi`) to `o_salida` under a valid/ready selection handshake. Channel changes are break-before-make: the output goes low on the old channel, holds low for a programmable dead time, and then re-enables on the new channel. This prevents runt pulses from reaching the downstream phase detector or counter. The block sits in the same slot as the 2:1 selector, between the phase-signal sources and the measurement logic, clocked by the system clock.

## Interface
- `N_CH`, 4: number of input channels, ≥2.
- `DEAD_CYC`, 4: forced-low cycles between channels, ≥1.
- `TIMEOUT_CYC`, 255: maximum cycles spent waiting for a channel to be sampled low, ≥1.
- `SEL_W` (localparam): `$clog2(N_CH)`.

- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_phi`  in  N_CH  phase signals; bit k is channel k.
- `i_sel`  in  SEL_W  requested channel.
- `i_sel_valid`  in  1  request strobe.
- `o_sel_ready`  out  1  block can accept a request (high only in IDLE).
- `o_salida`  out  1  registered selected signal.
- `o_active_sel`  out  SEL_W  channel currently routed.
- `o_switching`  out  1  high while a switch is in progress.
- `o_sel_err`  out  1  one-cycle pulse: request rejected because `i_sel` ≥ `N_CH`.
- `o_timeout`  out  1  one-cycle pulse: a wait-low phase expired.

## Operation
- `phi_s` is `i_phi` after the optional synchronizer (see Configuration).
- A request is accepted on the cycle where `i_sel_valid & o_sel_ready` is high. The requester holds `i_sel_valid` until accepted; requests made while busy are not queued.
- FSM states: IDLE, WAIT_OLD, DEAD, WAIT_NEW.
- **IDLE**: `o_salida <= phi_s[active]`. On an accepted request:
  - If `i_sel` ≥ `N_CH`: pulse `o_sel_err`; no change.
  - If `i_sel` == active: no-op; stay in IDLE, no gap in the output.
  - Otherwise: latch `i_sel` as `pending`; go to WAIT_OLD.
- **WAIT_OLD**: output keeps following the old channel. On the first cycle `phi_s[active]` == 0, gate the output low and go to DEAD.
- **DEAD**: `o_salida` = 0 for exactly `DEAD_CYC` cycles; then go to WAIT_NEW.
- **WAIT_NEW**: `o_salida` = 0. On the first cycle `phi_s[pending]` == 0, set `active <= pending`; go to IDLE.
- **Timeout**: in WAIT_OLD or WAIT_NEW, a wait counter runs. When it reaches `TIMEOUT_CYC` without the channel being sampled low, pulse `o_timeout` and proceed as if the low had been seen.
- `o_switching` is high in every state except IDLE.
- **Reset** (at any time, including mid-switch): `active` = 0, state IDLE, counters 0, `pending` discarded.
- Reset values: `o_salida` = 0, `o_active_sel` = 0, `o_switching` = 0, `o_sel_err` = 0, `o_timeout` = 0, `o_sel_ready` = 1.

## Timing
- `i_phi` to `o_salida`: 1 cycle, or 3 cycles with the synchronizer.
- Request accepted at cycle t:
  - WAIT_OLD is entered at t+1.
  - If old is sampled low at cycle k: DEAD spans k+1 .. k+DEAD_CYC.
  - If new is sampled low at cycle m: `o_active_sel` updates at m+1, and `o_salida` follows the new channel from m+2.
  - Best-case switch with both channels already low: ready returns at t+DEAD_CYC+3.
- `o_sel_err` pulses at t+1; `o_sel_ready` stays high throughout.
- Counter width: `$clog2(max(DEAD_CYC, TIMEOUT_CYC)+1)`. Counters saturate and never wrap.

## Configuration
- Macro: `SIGSEL_SYNC_EN`.
- Defined: each `i_phi` bit passes through a 2-flop synchronizer, reset to 0. Adds 2 cycles of latency to the data path and to all low-detection.
- Undefined: `phi_s = i_phi` directly. `i_phi` must then already be synchronous to `i_clk`.

## Structure
- Package `signal_selector_pkg` holds the FSM state enum (`ST_IDLE`, `ST_WAIT_OLD`, `ST_DEAD`, `ST_WAIT_NEW`) and the default parameter constants.
- Sub-module `sync_2ff` (1 bit, async active-low reset) is instantiated per channel under `SIGSEL_SYNC_EN`.

## Test plan
- **Reset**: assert `i_rst_n`=0 mid-switch (DEAD state) → all outputs reach their reset values immediately; after release, `o_active_sel`=0 and `o_salida` tracks `i_phi[0]` with 1-cycle latency.
- **Normal switch**: `N_CH`=4, `DEAD_CYC`=4; switch 0→2 with both channels toggling every 3 cycles → `o_salida` never pulses shorter than the source; ≥4 low cycles before ch2 appears; `o_active_sel`=2.
- **Same channel**: request `i_sel` = active → no `o_switching`, no output gap, ready stays 1.
- **Invalid select**: request `i_sel`=5 with `N_CH`=5 → `o_sel_err` pulses one cycle; active unchanged.
- **Stuck-high timeout**: hold the old channel at 1, `TIMEOUT_CYC`=8 → `o_timeout` pulses 8 cycles after WAIT_OLD is entered; the switch completes.
- **Busy request**: assert a request during DEAD → not accepted until ready returns; then accepted exactly once.

Source files
------------

// File: rtl/signal_selector_pkg.sv
// Shared types and defaults for the N-channel break-before-make phase-signal selector.
package signal_selector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_OLD = 2'd1,
        ST_DEAD     = 2'd2,
        ST_WAIT_NEW = 2'd3
    } sel_state_e;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_DEAD_CYC    = 4;
    localparam int DEF_TIMEOUT_CYC = 255;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/signal_selector_n_sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/signal_selector_n.sv
// N-channel phase-signal selector with break-before-make switching and a dead-time gap.
// Define SIGSEL_SYNC_EN to pass every i_phi bit through a 2-flop synchronizer.
module signal_selector_n
    import signal_selector_pkg::*;
#(
    parameter int  N_CH        = DEF_N_CH,
    parameter int  DEAD_CYC    = DEF_DEAD_CYC,
    parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int SEL_W       = $clog2(N_CH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_CH-1:0]  i_phi,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_sel_valid,
    output logic             o_sel_ready,
    output logic             o_salida,
    output logic [SEL_W-1:0] o_active_sel,
    output logic             o_switching,
    output logic             o_sel_err,
    output logic             o_timeout
);

    localparam int               CNT_W     = $clog2(max_int(DEAD_CYC, TIMEOUT_CYC) + 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [SEL_W:0]   N_CH_L    = (SEL_W + 1)'(N_CH);

    logic [N_CH-1:0]  phi_s;
    sel_state_e       state_q, state_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic [SEL_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             salida_q, salida_d;
    logic             sel_err_q, sel_err_d;
    logic             timeout_q, timeout_d;

    logic req_acc_s;
    logic sel_bad_s;
    logic sel_new_s;
    logic old_low_s;
    logic new_low_s;
    logic wait_exp_s;
    logic dead_done_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

`ifdef SIGSEL_SYNC_EN
    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        sync_2ff u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_d     (i_phi[g]),
            .o_q     (phi_s[g])
        );
    end
`else
    assign phi_s = i_phi;
`endif

    assign req_acc_s   = i_sel_valid & (state_q == ST_IDLE);
    assign sel_bad_s   = ({1'b0, i_sel} >= N_CH_L);
    assign sel_new_s   = ~sel_bad_s & (i_sel != active_q);
    assign old_low_s   = ~phi_s[active_q];
    assign new_low_s   = ~phi_s[pending_q];
    assign wait_exp_s  = (cnt_q >= WAIT_LAST);
    assign dead_done_s = (cnt_q >= DEAD_LAST);

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an expired wait proceeds exactly as if the low had been seen
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_acc_s && sel_new_s) begin
                    state_d = ST_WAIT_OLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_OLD: begin
                if (old_low_s || wait_exp_s) begin
                    state_d = ST_DEAD;
                end else begin
                    state_d = ST_WAIT_OLD;
                end
            end
            ST_DEAD: begin
                if (dead_done_s) begin
                    state_d = ST_WAIT_NEW;
                end else begin
                    state_d = ST_DEAD;
                end
            end
            ST_WAIT_NEW: begin
                if (new_low_s || wait_exp_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_NEW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next-state; output is gated low from the old-low cycle onward
    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        salida_d  = 1'b0;
        sel_err_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                salida_d  = phi_s[active_q];
                sel_err_d = req_acc_s & sel_bad_s;
                if (req_acc_s && sel_new_s) begin
                    pending_d = i_sel;
                end else begin
                    pending_d = pending_q;
                end
            end
            ST_WAIT_OLD: begin
                salida_d  = phi_s[active_q] & ~wait_exp_s;
                timeout_d = ~old_low_s & wait_exp_s;
            end
            ST_DEAD: begin
                salida_d = 1'b0;
            end
            ST_WAIT_NEW: begin
                timeout_d = ~new_low_s & wait_exp_s;
                if (new_low_s || wait_exp_s) begin
                    active_d = pending_q;
                end else begin
                    active_d = active_q;
                end
            end
            default: begin
                salida_d = 1'b0;
            end
        endcase

        if ((state_q == ST_IDLE) || (state_d != state_q)) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_q  <= {SEL_W{1'b0}};
            pending_q <= {SEL_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            salida_q  <= 1'b0;
            sel_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            salida_q  <= salida_d;
            sel_err_q <= sel_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_sel_ready  = (state_q == ST_IDLE);
    assign o_switching  = (state_q != ST_IDLE);
    assign o_salida     = salida_q;
    assign o_active_sel = active_q;
    assign o_sel_err    = sel_err_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_signal_selector_n.sv
// Randomised bench for signal_selector_n; expected outputs come from a timeline model of the switching rules.
module tb_signal_selector_n;

    localparam int N_CH        = 5;
    localparam int DEAD_CYC    = 4;
    localparam int TIMEOUT_CYC = 8;
    localparam int SEL_W       = 3;
    localparam int MAXC        = 600;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_CH-1:0]  phi = '0;
    logic [SEL_W-1:0] sel = '0;
    logic             sel_valid = 1'b0;
    logic             sel_ready;
    logic             salida;
    logic [SEL_W-1:0] active_sel;
    logic             switching;
    logic             sel_err;
    logic             timeout;

    always #5 clk = ~clk;

    signal_selector_n #(
        .N_CH        (N_CH),
        .DEAD_CYC    (DEAD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_phi        (phi),
        .i_sel        (sel),
        .i_sel_valid  (sel_valid),
        .o_sel_ready  (sel_ready),
        .o_salida     (salida),
        .o_active_sel (active_sel),
        .o_switching  (switching),
        .o_sel_err    (sel_err),
        .o_timeout    (timeout)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [N_CH-1:0]  stim_phi [MAXC];
    logic             drv_valid [MAXC];
    logic [SEL_W-1:0] drv_sel [MAXC];
    logic             e_salida [MAXC];
    logic             e_ready [MAXC];
    logic             e_sw [MAXC];
    logic             e_err [MAXC];
    logic             e_to [MAXC];
    logic             e_dead [MAXC];
    int               e_act [MAXC];
    int               req_t[$];
    int               req_s[$];
    int               mq_t[$];
    int               mq_s[$];
    int               seg_len;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic void note_cycle(input int j, input bit idle, input int act);
        e_ready[j] = idle;
        e_sw[j]    = !idle;
        e_act[j]   = act;
        if (mq_t.size() > 0 && mq_t[0] <= j) begin
            drv_valid[j] = 1'b1;
            drv_sel[j]   = SEL_W'(mq_s[0]);
        end
    endfunction

    // Walk the request list over the phi timeline; each switch is located by its old-low and new-low cycles
    task automatic build_model(input int plan_len);
        int c, act, t, k, m, s;
        mq_t = req_t;
        mq_s = req_s;
        for (int i = 0; i < MAXC; i++) begin
            e_salida[i] = 1'b0; e_ready[i] = 1'b1; e_sw[i] = 1'b0;
            e_err[i] = 1'b0; e_to[i] = 1'b0; e_dead[i] = 1'b0; e_act[i] = 0;
            drv_valid[i] = 1'b0; drv_sel[i] = SEL_W'($urandom);
        end
        c = 0;
        act = 0;
        while (c < plan_len) begin
            note_cycle(c, 1'b1, act);
            e_salida[c+1] = stim_phi[c][act];
            if (drv_valid[c]) begin
                s = mq_s.pop_front();
                void'(mq_t.pop_front());
                if (s >= N_CH) begin
                    e_err[c+1] = 1'b1;
                end else if (s != act) begin
                    t = c;
                    k = t + TIMEOUT_CYC;
                    for (int j = t + TIMEOUT_CYC; j >= t + 1; j--) if (!stim_phi[j][act]) k = j;
                    if (stim_phi[k][act]) e_to[k+1] = 1'b1;
                    for (int j = t + 1; j <= k; j++) begin
                        note_cycle(j, 1'b0, act);
                        e_salida[j+1] = (j < k) ? stim_phi[j][act] : 1'b0;
                    end
                    for (int j = k + 1; j <= k + DEAD_CYC; j++) begin
                        note_cycle(j, 1'b0, act);
                        e_dead[j] = 1'b1;
                        e_salida[j+1] = 1'b0;
                    end
                    m = k + DEAD_CYC + TIMEOUT_CYC;
                    for (int j = m; j >= k + DEAD_CYC + 1; j--) if (!stim_phi[j][s]) m = j;
                    if (stim_phi[m][s]) e_to[m+1] = 1'b1;
                    for (int j = k + DEAD_CYC + 1; j <= m; j++) begin
                        note_cycle(j, 1'b0, act);
                        e_salida[j+1] = 1'b0;
                    end
                    act = s;
                    c = m;
                end
            end
            c++;
        end
        seg_len = c;
    endtask

    task automatic check_reset_values();
        check_val("rst_salida", salida, 0);
        check_val("rst_active", active_sel, 0);
        check_val("rst_switching", switching, 0);
        check_val("rst_sel_err", sel_err, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_ready", sel_ready, 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        phi = '0;
        sel_valid = 1'b0;
        sel = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_segment(input int abort_at);
        for (int c = 0; c < seg_len; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            check_val("salida", salida, e_salida[c]);
            check_val("active_sel", active_sel, e_act[c]);
            check_val("sel_ready", sel_ready, e_ready[c]);
            check_val("switching", switching, e_sw[c]);
            check_val("sel_err", sel_err, e_err[c]);
            check_val("timeout", timeout, e_to[c]);
            phi = stim_phi[c];
            sel_valid = drv_valid[c];
            sel = drv_sel[c];
            if (c == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_values();
                break;
            end
        end
    endtask

    initial begin
        int r, abort_at;

        // Segment 1: staggered toggling channels, stuck-high stretch, then random traffic
        for (int c = 0; c < MAXC; c++) begin
            for (int k = 0; k < N_CH; k++) begin
                if (c < 60)       stim_phi[c][k] = (((c + k) / 3) % 2) == 1;
                else if (c < 120) stim_phi[c][k] = (k == 1 || k == 3) ? 1'b1 : ((((c + k) / 3) % 2) == 1);
                else              stim_phi[c][k] = ($urandom_range(0, 3) != 0);
            end
        end
        req_t = {5, 25, 30, 33, 60, 62, 64};
        req_s = {2, 2, 5, 1, 3, 0, 7};
        r = 130;
        while (r < 400) begin
            req_t.push_back(r);
            req_s.push_back($urandom_range(0, 7));
            r += $urandom_range(3, 25);
        end
        build_model(420);
        apply_reset();
        run_segment(-1);

        // Segment 2: two switches on idle-low channels, reset asserted during the second dead time
        for (int c = 0; c < MAXC; c++) stim_phi[c] = '0;
        req_t = {2, 20};
        req_s = {3, 1};
        build_model(30);
        abort_at = -1;
        for (int c = seg_len - 1; c >= 0; c--) begin
            if (e_dead[c] && abort_at < 0) abort_at = c - 1;
        end
        apply_reset();
        run_segment(abort_at);

        // Segment 3: fully random after reset, active channel starts at 0
        for (int c = 0; c < MAXC; c++) begin
            for (int k = 0; k < N_CH; k++) stim_phi[c][k] = ($urandom_range(0, 2) != 0);
        end
        req_t.delete();
        req_s.delete();
        r = 3;
        while (r < 280) begin
            req_t.push_back(r);
            req_s.push_back($urandom_range(0, 7));
            r += $urandom_range(2, 20);
        end
        build_model(300);
        apply_reset();
        run_segment(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
